// File: rtl/crg_pkg.sv
// Shared types, encodings and lane helpers for the correlated randomness generator.
package crg_pkg;

    typedef logic [127:0] key_t;
    typedef logic [31:0]  cr_cnt_t;
    typedef logic [255:0] prng_t;

    // Lane width encodings
    localparam logic [2:0] Width32  = 3'b000;
    localparam logic [2:0] Width64  = 3'b001;
    localparam logic [2:0] Width128 = 3'b011;
    localparam logic [2:0] Width256 = 3'b111;

    // Mode encodings
    localparam logic [2:0] ModeArith = 3'b100;
    localparam logic [2:0] ModeBool  = 3'b010;
    localparam logic [2:0] ModeExt   = 3'b001;

    // Stream IDs
    localparam logic [2:0] StreamA  = 3'd0;
    localparam logic [2:0] StreamB  = 3'd1;
    localparam logic [2:0] StreamRa = 3'd2;
    localparam logic [2:0] StreamRb = 3'd3;
    localparam logic [2:0] StreamRc = 3'd4;

    // splitmix64 finalizer multipliers
    localparam logic [63:0] SmC1 = 64'hBF58476D1CE4E5B9;
    localparam logic [63:0] SmC2 = 64'h94D049BB133111EB;

    typedef enum logic {StIdle, StRun} state_e;

    typedef struct packed {
        logic       party;
        logic [2:0] mode;
        logic [2:0] width;
    } cfg_t;

    // Per-lane product mod 2^W; unknown width codes fall back to 32-bit lanes.
    function automatic prng_t lane_mul(input prng_t x, input prng_t y, input logic [2:0] width);
        prng_t r;
        r = '0;
        case (width)
            Width64:  for (int i = 0; i < 4; i++) r[i*64 +: 64] = x[i*64 +: 64] * y[i*64 +: 64];
            Width128: for (int i = 0; i < 2; i++) r[i*128 +: 128] = x[i*128 +: 128] * y[i*128 +: 128];
            Width256: r = x * y;
            default:  for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] * y[i*32 +: 32];
        endcase
        return r;
    endfunction

    // Per-lane difference mod 2^W.
    function automatic prng_t lane_sub(input prng_t x, input prng_t y, input logic [2:0] width);
        prng_t r;
        r = '0;
        case (width)
            Width64:  for (int i = 0; i < 4; i++) r[i*64 +: 64] = x[i*64 +: 64] - y[i*64 +: 64];
            Width128: for (int i = 0; i < 2; i++) r[i*128 +: 128] = x[i*128 +: 128] - y[i*128 +: 128];
            Width256: r = x - y;
            default:  for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] - y[i*32 +: 32];
        endcase
        return r;
    endfunction

    // Keep only bit 0 of every lane.
    function automatic prng_t lane_lsb(input prng_t x, input logic [2:0] width);
        prng_t r;
        r = '0;
        case (width)
            Width64:  for (int i = 0; i < 4; i++) r[i*64] = x[i*64];
            Width128: for (int i = 0; i < 2; i++) r[i*128] = x[i*128];
            Width256: r[0] = x[0];
            default:  for (int i = 0; i < 8; i++) r[i*32] = x[i*32];
        endcase
        return r;
    endfunction

    // Gather bit 'pos' of each lane into bit j; bits past the lane count stay 0.
    function automatic logic [7:0] lane_bits(input prng_t x, input logic [2:0] width,
                                             input int unsigned pos);
        logic [7:0] r;
        r = '0;
        case (width)
            Width64:  for (int i = 0; i < 4; i++) r[i] = x[i*64 + pos];
            Width128: for (int i = 0; i < 2; i++) r[i] = x[i*128 + pos];
            Width256: r[0] = x[pos];
            default:  for (int i = 0; i < 8; i++) r[i] = x[i*32 + pos];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/crg_if.sv
// Control and share-output bundle between session control, crg and the compute lanes.
interface crg_if;
    import crg_pkg::*;

    logic       party_i;
    key_t       key_i;
    logic [2:0] width_i;
    logic [2:0] mode_i;
    cr_cnt_t    cnt_start_i;
    cr_cnt_t    cnt_end_i;
    logic       run_i;
    prng_t      a_o;
    prng_t      b_o;
    prng_t      c_o;
    logic [7:0] e_o;
    logic       dvld_o;

    modport master (
        output party_i, key_i, width_i, mode_i, cnt_start_i, cnt_end_i, run_i,
        input  a_o, b_o, c_o, e_o, dvld_o
    );

    modport slave (
        input  party_i, key_i, width_i, mode_i, cnt_start_i, cnt_end_i, run_i,
        output a_o, b_o, c_o, e_o, dvld_o
    );

endinterface

// File: rtl/crg_prf.sv
// Four-stage pipelined splitmix64 word generator for one (stream, word) slot.
module crg_prf
    import crg_pkg::*;
#(
    parameter logic [2:0] Stream = 3'd0,
    parameter logic [1:0] Word   = 2'd0
) (
    input  logic        clk,
    input  key_t        key,
    input  cr_cnt_t     cnt,
    output logic [63:0] word
);

    logic [63:0] seed;
    logic [63:0] mix3;
    logic [63:0] s1_q, s2_q, s3_q, s4_q;

    // Seed from key/counter/slot and the xor-shift that sits between the two multipliers.
    always_comb begin
        seed = (key[63:0] ^ {cnt, 27'd0, Stream, Word}) + key[127:64];
        mix3 = s2_q ^ (s2_q >> 27);
    end

    // Finalizer split as: xs30 | mul1 | xs27+mul2 | xs31.
    always_ff @(posedge clk) begin
        s1_q <= seed ^ (seed >> 30);
        s2_q <= s1_q * SmC1;
        s3_q <= mix3 * SmC2;
        s4_q <= s3_q ^ (s3_q >> 31);
    end

    assign word = s4_q;

endmodule

// File: rtl/crg.sv
// Correlated randomness generator: one secret-shared multiplication triple per cycle.
// Optional feature macro: CRG_EXTENDED_EN (extended mode and e_o generation).
module crg
    import crg_pkg::*;
(
    input logic clk_i,
    input logic rst_i,
    crg_if.slave bus
);

    state_e      state_q, state_d;
    key_t        key_q;
    cr_cnt_t     k_q, k_d, end_q;
    cfg_t        cfg_q;
    logic        load, issue;

    logic [3:0]  vld_q;
    cfg_t        cfg_p_q [4];
    logic        comb_vld_q;
    cfg_t        cfg_c_q;

    logic [63:0] prf_word [5][4];
    prng_t       str [5];

    prng_t       a_n, b_n, c_n;
    logic [7:0]  e_n;
    prng_t       a_c_q, b_c_q, c_c_q, ra_c_q, rb_c_q, rc_c_q;
    logic [7:0]  e_c_q;

    prng_t       a_s, b_s, c_s;
    prng_t       a_q, b_q, c_q;
    logic [7:0]  e_q;
    logic        dvld_q;

    // Sequencer: load run parameters from idle, then issue k up to and including end.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        load    = 1'b0;
        issue   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.run_i) begin
                    state_d = StRun;
                    k_d     = bus.cnt_start_i;
                    load    = 1'b1;
                end
            end
            StRun: begin
                issue = 1'b1;
                k_d   = k_q + 32'd1;
                // end < start also stops here, after the single k = start
                if (k_q >= end_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Run parameters captured on the accepted start pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q <= '0;
            end_q <= '0;
            cfg_q <= '0;
        end else if (load) begin
            key_q <= bus.key_i;
            end_q <= bus.cnt_end_i;
            cfg_q <= '{party: bus.party_i, mode: bus.mode_i, width: bus.width_i};
        end
    end

    for (genvar s = 0; s < 5; s++) begin : g_stream
        for (genvar w = 0; w < 4; w++) begin : g_word
            crg_prf #(
                .Stream (3'(s)),
                .Word   (2'(w))
            ) u_prf (
                .clk  (clk_i),
                .key  (key_q),
                .cnt  (k_q),
                .word (prf_word[s][w])
            );
        end
    end

    // Assemble each 256-bit stream value as {w3, w2, w1, w0}.
    always_comb begin
        for (int s = 0; s < 5; s++) begin
            str[s] = {prf_word[s][3], prf_word[s][2], prf_word[s][1], prf_word[s][0]};
        end
    end

    // Valid bits travel with the words; cleared on reset so an aborted run emits nothing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q      <= '0;
            comb_vld_q <= 1'b0;
        end else begin
            vld_q      <= {vld_q[2:0], issue};
            comb_vld_q <= vld_q[3];
        end
    end

    // Run configuration follows its triples so a back-to-back run cannot corrupt the tail.
    always_ff @(posedge clk_i) begin
        cfg_p_q[0] <= cfg_q;
        for (int i = 1; i < 4; i++) cfg_p_q[i] <= cfg_p_q[i-1];
        cfg_c_q <= cfg_p_q[3];
    end

    // Combine stage: true a, b, c (and extended e shares) from the PRF streams.
    always_comb begin
        a_n = str[StreamA];
        b_n = str[StreamB];
        e_n = '0;
`ifdef CRG_EXTENDED_EN
        if (cfg_p_q[3].mode == ModeExt) begin
            a_n = lane_lsb(str[StreamA], cfg_p_q[3].width);
            e_n = lane_bits(str[StreamRa], cfg_p_q[3].width, 1)
                ^ (cfg_p_q[3].party ? lane_bits(a_n, cfg_p_q[3].width, 0) : 8'd0);
        end
`endif
        if (cfg_p_q[3].mode == ModeBool) c_n = a_n & b_n;
        else                             c_n = lane_mul(a_n, b_n, cfg_p_q[3].width);
    end

    // Combine-stage register.
    always_ff @(posedge clk_i) begin
        a_c_q  <= a_n;
        b_c_q  <= b_n;
        c_c_q  <= c_n;
        ra_c_q <= str[StreamRa];
        rb_c_q <= str[StreamRb];
        rc_c_q <= str[StreamRc];
        e_c_q  <= e_n;
    end

    // Share selection: party 0 takes the masks, party 1 the masked complement.
    always_comb begin
        a_s = ra_c_q;
        b_s = rb_c_q;
        c_s = rc_c_q;
        if (cfg_c_q.party) begin
            if (cfg_c_q.mode == ModeBool) begin
                a_s = a_c_q ^ ra_c_q;
                b_s = b_c_q ^ rb_c_q;
                c_s = c_c_q ^ rc_c_q;
            end else begin
                a_s = lane_sub(a_c_q, ra_c_q, cfg_c_q.width);
                b_s = lane_sub(b_c_q, rb_c_q, cfg_c_q.width);
                c_s = lane_sub(c_c_q, rc_c_q, cfg_c_q.width);
            end
        end
    end

    // Output register: loads only on valid triples so the last one holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            e_q    <= '0;
            dvld_q <= 1'b0;
        end else begin
            dvld_q <= comb_vld_q;
            if (comb_vld_q) begin
                a_q <= a_s;
                b_q <= b_s;
                c_q <= c_s;
                e_q <= e_c_q;
            end
        end
    end

    assign bus.a_o    = a_q;
    assign bus.b_o    = b_q;
    assign bus.c_o    = c_q;
    assign bus.e_o    = e_q;
    assign bus.dvld_o = dvld_q;

endmodule

// File: tb/tb_crg.sv
// Two-party bench for crg: per-party reference model plus share reconstruction checks.
module tb_crg;
    import crg_pkg::*;

`ifdef CRG_EXTENDED_EN
    localparam bit ExtEn = 1'b1;
`else
    localparam bit ExtEn = 1'b0;
`endif

    localparam key_t SpecKey = 128'he3e70682c2094cac629f6fbed82c07cd;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    crg_if if0 ();
    crg_if if1 ();

    crg u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    crg u1 (.clk_i(clk), .rst_i(rst), .bus(if1));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sm_word(input key_t key, input logic [31:0] k,
                                            input int s, input int w);
        logic [63:0] z;
        logic [2:0]  s3;
        logic [1:0]  w2;
        s3 = 3'(s);
        w2 = 2'(w);
        z = (key[63:0] ^ {k, 27'd0, s3, w2}) + key[127:64];
        z = z ^ (z >> 30);
        z = z * 64'hBF58476D1CE4E5B9;
        z = z ^ (z >> 27);
        z = z * 64'h94D049BB133111EB;
        z = z ^ (z >> 31);
        return z;
    endfunction

    function automatic logic [255:0] stream(input key_t key, input logic [31:0] k, input int s);
        logic [255:0] v;
        v = '0;
        for (int w = 0; w < 4; w++) v = v | (256'(sm_word(key, k, s, w)) << (64 * w));
        return v;
    endfunction

    function automatic int lane_w(input logic [2:0] width);
        case (width)
            3'b001:  return 64;
            3'b011:  return 128;
            3'b111:  return 256;
            default: return 32;
        endcase
    endfunction

    function automatic logic [255:0] lane_mask(input int w);
        logic [255:0] m;
        m = '1;
        if (w < 256) m = m >> (256 - w);
        return m;
    endfunction

    // Expected shares of one party for counter value k.
    task automatic model(input key_t key, input logic [31:0] k, input bit party,
                         input logic [2:0] mode, input logic [2:0] width,
                         output logic [255:0] ea, output logic [255:0] eb,
                         output logic [255:0] ec, output logic [7:0] ee);
        logic [255:0] sa, sb, ra, rb, rc, m, la, lb, lc, lra, lrb, lrc;
        int w, nl;
        bit ext, rbit;
        sa = stream(key, k, 0);
        sb = stream(key, k, 1);
        ra = stream(key, k, 2);
        rb = stream(key, k, 3);
        rc = stream(key, k, 4);
        ee = '0;
        if (mode == 3'b010) begin
            ea = party ? (sa ^ ra) : ra;
            eb = party ? (sb ^ rb) : rb;
            ec = party ? ((sa & sb) ^ rc) : rc;
        end else begin
            ext = (mode == 3'b001) && ExtEn;
            w   = lane_w(width);
            nl  = 256 / w;
            m   = lane_mask(w);
            ea  = '0;
            eb  = '0;
            ec  = '0;
            for (int j = 0; j < nl; j++) begin
                la  = (sa >> (j * w)) & m;
                if (ext) la = la & 256'd1;
                lb  = (sb >> (j * w)) & m;
                lc  = (la * lb) & m;
                lra = (ra >> (j * w)) & m;
                lrb = (rb >> (j * w)) & m;
                lrc = (rc >> (j * w)) & m;
                ea  = ea | (((party ? la - lra : lra) & m) << (j * w));
                eb  = eb | (((party ? lb - lrb : lrb) & m) << (j * w));
                ec  = ec | (((party ? lc - lrc : lrc) & m) << (j * w));
                if (ext) begin
                    rbit  = ra[j * w + 1];
                    ee[j] = party ? (rbit ^ la[0]) : rbit;
                end
            end
        end
    endtask

    // Combined shares of both parties must form a valid triple.
    task automatic recon(input logic [2:0] mode, input logic [2:0] width);
        logic [255:0] m, la, lb, lc;
        int w, nl;
        bit ext;
        if (mode == 3'b010) begin
            chk("bool_recon", (if0.a_o ^ if1.a_o) & (if0.b_o ^ if1.b_o), if0.c_o ^ if1.c_o);
        end else begin
            ext = (mode == 3'b001) && ExtEn;
            w   = lane_w(width);
            nl  = 256 / w;
            m   = lane_mask(w);
            for (int j = 0; j < nl; j++) begin
                la = ((if0.a_o >> (j * w)) + (if1.a_o >> (j * w))) & m;
                lb = ((if0.b_o >> (j * w)) + (if1.b_o >> (j * w))) & m;
                lc = ((if0.c_o >> (j * w)) + (if1.c_o >> (j * w))) & m;
                chk("arith_recon", lc, (la * lb) & m);
                if (ext) begin
                    chk("ext_a_binary", 256'(la > 256'd1), 256'd0);
                    chk("ext_e_recon", 256'(if0.e_o[j] ^ if1.e_o[j]), 256'(la[0]));
                end
            end
        end
    endtask

    task automatic drive(input key_t key, input cr_cnt_t st, input cr_cnt_t en,
                         input logic [2:0] mode, input logic [2:0] width, input logic run);
        if0.key_i = key;  if0.cnt_start_i = st; if0.cnt_end_i = en;
        if0.mode_i = mode; if0.width_i = width; if0.run_i = run;
        if1.key_i = key;  if1.cnt_start_i = st; if1.cnt_end_i = en;
        if1.mode_i = mode; if1.width_i = width; if1.run_i = run;
    endtask

    task automatic chk_party(input string tag, input bit party, input key_t key,
                             input logic [31:0] k, input logic [2:0] mode,
                             input logic [2:0] width);
        logic [255:0] ea, eb, ec;
        logic [7:0]   ee;
        model(key, k, party, mode, width, ea, eb, ec, ee);
        if (party) begin
            chk({tag, "_a1"}, if1.a_o, ea); chk({tag, "_b1"}, if1.b_o, eb);
            chk({tag, "_c1"}, if1.c_o, ec); chk({tag, "_e1"}, 256'(if1.e_o), 256'(ee));
        end else begin
            chk({tag, "_a0"}, if0.a_o, ea); chk({tag, "_b0"}, if0.b_o, eb);
            chk({tag, "_c0"}, if0.c_o, ec); chk({tag, "_e0"}, 256'(if0.e_o), 256'(ee));
        end
    endtask

    // One run: pulse run_i, then check dvld timing, every triple, and the held tail.
    task automatic do_run(input string tag, input key_t key, input cr_cnt_t st,
                          input cr_cnt_t en, input logic [2:0] mode,
                          input logic [2:0] width, input bit poke);
        int nt, idx;
        bit exp_v;
        logic [31:0] kk;
        nt = (en < st) ? 1 : int'(en - st) + 1;
        @(negedge clk);
        drive(key, st, en, mode, width, 1'b1);
        for (int n = 1; n <= nt + 9; n++) begin
            @(negedge clk);
            exp_v = (n >= 7) && (n < 7 + nt);
            chk({tag, "_dvld0"}, 256'(if0.dvld_o), 256'(exp_v));
            chk({tag, "_dvld1"}, 256'(if1.dvld_o), 256'(exp_v));
            if (n >= 7) begin
                idx = exp_v ? n - 7 : nt - 1;
                kk  = st + 32'(idx);
                chk_party(tag, 1'b0, key, kk, mode, width);
                chk_party(tag, 1'b1, key, kk, mode, width);
                recon(mode, width);
            end
            if (n == 1) drive(key, st, en, mode, width, 1'b0);
            // A start pulse mid-run with different inputs must have no effect.
            if (poke && n == 3) drive(~key, st + 32'd50, en + 32'd9, mode, width, 1'b1);
            if (poke && n == 4) drive(~key, st + 32'd50, en + 32'd9, mode, width, 1'b0);
        end
    endtask

    task automatic do_abort(input key_t key, input cr_cnt_t st, input cr_cnt_t en);
        @(negedge clk);
        drive(key, st, en, ModeArith, Width64, 1'b1);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            chk("abort_dvld0", 256'(if0.dvld_o), 256'd0);
            chk("abort_dvld1", 256'(if1.dvld_o), 256'd0);
            if (n >= 4) begin
                chk("abort_a0", if0.a_o, 256'd0);
                chk("abort_c1", if1.c_o, 256'd0);
                chk("abort_e0", 256'(if0.e_o), 256'd0);
            end
            if (n == 1) drive(key, st, en, ModeArith, Width64, 1'b0);
            if (n == 3) rst = 1'b1;
            if (n == 4) rst = 1'b0;
        end
    endtask

    logic [2:0] modes  [3] = '{ModeArith, ModeBool, ModeExt};
    logic [2:0] widths [4] = '{Width32, Width64, Width128, Width256};

    initial begin
        key_t       rkey;
        cr_cnt_t    rst_cnt, ren;
        logic [2:0] rmode, rwidth;

        rst = 1'b1;
        if0.party_i = 1'b0;
        if1.party_i = 1'b1;
        drive('0, '0, '0, ModeArith, Width32, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_dvld", 256'({if0.dvld_o, if1.dvld_o}), 256'd0);
            chk("reset_a0", if0.a_o, 256'd0);
            chk("reset_b1", if1.b_o, 256'd0);
            chk("reset_c0", if0.c_o, 256'd0);
        end
        rst = 1'b0;

        do_run("arith_w32", SpecKey, 32'd3, 32'h13, ModeArith, Width32, 1'b1);
        do_run("arith_w64", SpecKey, 32'd3, 32'h13, ModeArith, Width64, 1'b0);
        do_run("arith_w128", SpecKey, 32'd3, 32'h13, ModeArith, Width128, 1'b0);
        do_run("arith_w256", SpecKey, 32'd3, 32'h13, ModeArith, Width256, 1'b0);
        do_run("bool_w128", SpecKey, 32'd3, 32'h13, ModeBool, Width128, 1'b0);
        do_run("ext_w32", SpecKey, 32'd3, 32'h13, ModeExt, Width32, 1'b0);
        do_run("ext_w64", SpecKey, 32'd3, 32'h13, ModeExt, Width64, 1'b0);
        do_run("rev_range", SpecKey, 32'd5, 32'd2, ModeArith, Width64, 1'b0);
        do_run("rev_rerun", SpecKey, 32'd5, 32'd2, ModeArith, Width64, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rkey    = {$urandom, $urandom, $urandom, $urandom};
            rmode   = modes[$urandom_range(0, 2)];
            rwidth  = (rmode == ModeExt) ? widths[$urandom_range(0, 1)]
                                         : widths[$urandom_range(0, 3)];
            rst_cnt = cr_cnt_t'($urandom_range(2, 1000));
            ren     = (r == 5) ? rst_cnt - 32'd2 : rst_cnt + cr_cnt_t'($urandom_range(0, 4));
            do_run("rand", rkey, rst_cnt, ren, rmode, rwidth, 1'b0);
        end

        do_abort(SpecKey, 32'd3, 32'h13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
